// File: rtl/decimal_entry_pkg.sv
// Shared calculator definitions: entry FSM encoding and operand limits.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StError
  } entry_state_e;

  localparam int unsigned BCD_MAX   = 9;
  localparam int unsigned MAG_LIMIT = 128;
  localparam int unsigned OPERAND_W = 8;

endpackage

// File: rtl/decimal_entry_dec_mac.sv
// Decimal multiply-accumulate: mag*10 + digit, with a flag when the result exceeds MAG_LIMIT.
module dec_mac
  import decimal_entry_pkg::*;
(
  input  logic [OPERAND_W-1:0] mag_i,
  input  logic [3:0]           digit_i,
  output logic [11:0]          sum_o,
  output logic                 over_o
);

  // 128*10 + 15 fits comfortably in 12 bits, so no wrap is possible.
  assign sum_o  = (12'(mag_i) * 12'd10) + 12'(digit_i);
  assign over_o = (sum_o > 12'(MAG_LIMIT));

endmodule

// File: rtl/decimal_entry.sv
// Builds a signed 8-bit operand from BCD digit strobes with sign toggle; commits on enter.
module decimal_entry
  import decimal_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           digit_in,
  input  logic                 digit_stb,
  input  logic                 neg_stb,
  input  logic                 enter_stb,
  input  logic                 clear_stb,
  output logic [OPERAND_W-1:0] value,
  output logic                 value_valid,
  output logic [OPERAND_W-1:0] entry_mag,
  output logic                 entry_neg,
  output logic                 entry_active,
  output logic                 err
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  entry_state_e         state_q, state_d;
  logic [OPERAND_W-1:0] mag_q, mag_d;
  logic                 neg_q, neg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [OPERAND_W-1:0] value_q, value_d;
  logic                 valid_q, valid_d;

  logic [11:0] mac_sum;
  logic        mac_over;
  logic        unused_mac_hi;

  dec_mac u_dec_mac (
    .mag_i   (mag_q),
    .digit_i (digit_in),
    .sum_o   (mac_sum),
    .over_o  (mac_over)
  );

  assign unused_mac_hi = ^mac_sum[11:OPERAND_W];

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;

    if (clear_stb) begin
      state_d = StIdle;
      mag_d   = '0;
      neg_d   = 1'b0;
      cnt_d   = '0;
    end else if (state_q != StError) begin
      // Priority enter > digit > neg; an enter in idle still swallows lower strobes.
      if (enter_stb) begin
        if (state_q == StEntry) begin
          if (!neg_q && (mag_q == OPERAND_W'(MAG_LIMIT))) begin
            state_d = StError;
          end else begin
            value_d = neg_q ? (~mag_q + OPERAND_W'(1)) : mag_q;
            valid_d = 1'b1;
            state_d = StIdle;
            mag_d   = '0;
            neg_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end else if (digit_stb) begin
        if ((digit_in > 4'(BCD_MAX)) || (cnt_q >= CntW'(MAX_DIGITS)) || mac_over) begin
          state_d = StError;
        end else begin
          mag_d   = mac_sum[OPERAND_W-1:0];
          cnt_d   = cnt_q + CntW'(1);
          state_d = StEntry;
        end
      end else if (neg_stb) begin
        neg_d   = ~neg_q;
        state_d = StEntry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  assign value        = value_q;
  assign value_valid  = valid_q;
  assign entry_mag    = mag_q;
  assign entry_neg    = neg_q;
  assign entry_active = (state_q == StEntry);
  assign err          = (state_q == StError);

endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: digit entry, sign, commit, error paths, priority, reset.
module tb_decimal_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic       digit_stb = 1'b0;
  logic       neg_stb = 1'b0;
  logic       enter_stb = 1'b0;
  logic       clear_stb = 1'b0;
  logic [7:0] value;
  logic       value_valid;
  logic [7:0] entry_mag;
  logic       entry_neg;
  logic       entry_active;
  logic       err;

  int checks = 0;
  int errors = 0;

  decimal_entry #(.MAX_DIGITS(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_stb    (digit_stb),
    .neg_stb      (neg_stb),
    .enter_stb    (enter_stb),
    .clear_stb    (clear_stb),
    .value        (value),
    .value_valid  (value_valid),
    .entry_mag    (entry_mag),
    .entry_neg    (entry_neg),
    .entry_active (entry_active),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample 1ns after the edge.
  task automatic step(input logic [3:0] d, input logic ds, input logic ns, input logic es,
                      input logic cs);
    digit_in  = d;
    digit_stb = ds;
    neg_stb   = ns;
    enter_stb = es;
    clear_stb = cs;
    @(posedge clk);
    #1;
    digit_stb = 1'b0;
    neg_stb   = 1'b0;
    enter_stb = 1'b0;
    clear_stb = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);
    step(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter();
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic clear();
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic neg();
    step(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_value", value, 8'h00);
    chk("rst_valid", 8'(value_valid), 8'h0);
    chk("rst_mag", entry_mag, 8'h00);
    chk("rst_neg", 8'(entry_neg), 8'h0);
    chk("rst_active", 8'(entry_active), 8'h0);
    chk("rst_err", 8'(err), 8'h0);

    // 127 commit
    dig(4'd1);
    chk("d1_active", 8'(entry_active), 8'h1);
    dig(4'd2);
    dig(4'd7);
    chk("mag_127", entry_mag, 8'd127);
    enter();
    chk("val_7f", value, 8'h7F);
    chk("valid_7f", 8'(value_valid), 8'h1);
    chk("mag_after_7f", entry_mag, 8'h00);
    chk("active_after_7f", 8'(entry_active), 8'h0);
    chk("err_after_7f", 8'(err), 8'h0);
    step(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("valid_one_cycle", 8'(value_valid), 8'h0);
    chk("val_hold", value, 8'h7F);

    // Enter in idle ignored
    enter();
    chk("idle_enter_valid", 8'(value_valid), 8'h0);
    chk("idle_enter_val", value, 8'h7F);

    // -128
    neg();
    chk("neg_sign", 8'(entry_neg), 8'h1);
    chk("neg_active", 8'(entry_active), 8'h1);
    dig(4'd1);
    dig(4'd2);
    dig(4'd8);
    chk("mag_128", entry_mag, 8'd128);
    enter();
    chk("val_80", value, 8'h80);
    chk("valid_80", 8'(value_valid), 8'h1);
    chk("neg_cleared", 8'(entry_neg), 8'h0);

    // +128 rejected at enter
    dig(4'd1);
    dig(4'd2);
    dig(4'd8);
    enter();
    chk("p128_err", 8'(err), 8'h1);
    chk("p128_valid", 8'(value_valid), 8'h0);
    chk("p128_val", value, 8'h80);
    chk("p128_mag_frozen", entry_mag, 8'd128);
    clear();
    chk("clr_err", 8'(err), 8'h0);
    chk("clr_active", 8'(entry_active), 8'h0);
    chk("clr_mag", entry_mag, 8'h00);
    chk("clr_val", value, 8'h80);

    // 260 overflow, then ERROR ignores enter/digit/neg
    dig(4'd2);
    dig(4'd6);
    dig(4'd0);
    chk("ovf_err", 8'(err), 8'h1);
    chk("ovf_mag", entry_mag, 8'd26);
    enter();
    chk("errst_valid", 8'(value_valid), 8'h0);
    chk("errst_val", value, 8'h80);
    dig(4'd3);
    chk("errst_mag", entry_mag, 8'd26);
    neg();
    chk("errst_neg", 8'(entry_neg), 8'h0);
    chk("errst_err", 8'(err), 8'h1);
    clear();

    // Non-BCD digit
    dig(4'd12);
    chk("bcd_err", 8'(err), 8'h1);
    chk("bcd_mag", entry_mag, 8'h00);
    clear();

    // Leading zeros count toward digit limit
    dig(4'd0);
    dig(4'd0);
    dig(4'd0);
    chk("zeros_err", 8'(err), 8'h0);
    chk("zeros_active", 8'(entry_active), 8'h1);
    dig(4'd5);
    chk("fourth_err", 8'(err), 8'h1);
    chk("fourth_mag", entry_mag, 8'h00);
    clear();

    // Sign only commits zero
    neg();
    enter();
    chk("negzero_val", value, 8'h00);
    chk("negzero_valid", 8'(value_valid), 8'h1);

    // Enter beats digit
    dig(4'd4);
    step(4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("prio_val", value, 8'h04);
    chk("prio_valid", 8'(value_valid), 8'h1);
    chk("prio_mag", entry_mag, 8'h00);
    chk("prio_active", 8'(entry_active), 8'h0);

    // Clear beats enter
    dig(4'd5);
    step(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clrprio_valid", 8'(value_valid), 8'h0);
    chk("clrprio_active", 8'(entry_active), 8'h0);
    chk("clrprio_mag", entry_mag, 8'h00);
    chk("clrprio_val", value, 8'h04);

    // Reset mid-entry
    dig(4'd4);
    dig(4'd5);
    neg();
    chk("mid_mag", entry_mag, 8'd45);
    chk("mid_neg", 8'(entry_neg), 8'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_value", value, 8'h00);
    chk("mrst_valid", 8'(value_valid), 8'h0);
    chk("mrst_mag", entry_mag, 8'h00);
    chk("mrst_neg", 8'(entry_neg), 8'h0);
    chk("mrst_active", 8'(entry_active), 8'h0);
    chk("mrst_err", 8'(err), 8'h0);
    enter();
    chk("mrst_enter_valid", 8'(value_valid), 8'h0);
    chk("mrst_enter_val", value, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decimal_entry.md
# decimal_entry

Operand-entry block for the RPN calculator: the input-side counterpart of the two's-complement decimal display path. It takes a BCD digit from the slide switches plus single-cycle key strobes and builds a signed 8-bit operand one decimal digit at a time, with a sign toggle. On Enter it emits the finished two's-complement value with a one-cycle valid pulse, and it flags out-of-range or malformed entries. It sits between the debounce/falling-edge key front end and the operand stack. Its live entry outputs drive the decimal display while the user is typing.

## Interface
- MAX_DIGITS, default 3: maximum decimal digits accepted per operand.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- digit_in  in  4  BCD digit from switches, sampled only when digit_stb=1.
- digit_stb  in  1  one-cycle strobe: append digit_in.
- neg_stb  in  1  one-cycle strobe: toggle sign of current entry.
- enter_stb  in  1  one-cycle strobe: commit current entry.
- clear_stb  in  1  one-cycle strobe: abandon entry and clear error.
- value  out  8  signed committed operand; holds until the next commit.
- value_valid  out  1  one-cycle pulse: value has just updated.
- entry_mag  out  8  unsigned magnitude being typed (0..128).
- entry_neg  out  1  sign of the entry being typed.
- entry_active  out  1  1 once a digit has been accepted or the sign has been toggled.
- err  out  1  level; entry rejected, held until clear_stb or rst.

## Operation
- States:
  - IDLE: no entry in progress.
  - ENTRY: at least one digit or a sign toggle pending.
  - ERROR: entry rejected.
- Strobe priority when several are high in one cycle: clear > enter > digit > neg. Only the highest-priority strobe acts.
- Digit in IDLE or ENTRY:
  - If digit_in > 9, or MAX_DIGITS digits are already held, go to ERROR.
  - Otherwise compute new = entry_mag*10 + digit_in in 12 bits.
  - If new > 128, go to ERROR. Otherwise entry_mag <= new[7:0], increment the digit count, go to ENTRY.
- Leading zeros count toward MAX_DIGITS.
- Neg in IDLE or ENTRY: entry_neg toggles, state becomes ENTRY.
- Enter in IDLE: ignored; no pulse, value unchanged.
- Enter in ENTRY:
  - If entry_neg=0 and entry_mag=128, go to ERROR.
  - Otherwise value <= entry_neg ? -entry_mag : entry_mag (two's complement, 8 bits), pulse value_valid, reset the entry, go to IDLE.
- Enter with sign only and no digits commits 0; -0 commits as 8'h00.
- Clear in any state: reset the entry, err=0, go to IDLE. value is unchanged.
- ERROR: all strobes except clear are ignored. entry_mag and entry_neg freeze at their last good values.
- "Reset the entry" means entry_mag=0, entry_neg=0, digit count=0, entry_active=0.

## Timing
- All outputs are registered. A strobe sampled at edge N is reflected in the outputs after edge N; there is no combinational input-to-output path.
- value_valid is high for exactly the one cycle following the accepting enter edge. Back-to-back operands therefore give at most one pulse per enter.
- The strobe that triggers an error sets err in the same update.
- Reset values, applied on the first rising edge with rst=1, including mid-entry and mid-error:
  - state=IDLE
  - value=8'h00
  - value_valid=0
  - entry_mag=0
  - entry_neg=0
  - entry_active=0
  - err=0
  - digit count=0
- Strobes are assumed single-cycle. A strobe held high acts on every cycle it is high.

## Structure
- Shared calculator package holds:
  - state encoding (IDLE, ENTRY, ERROR);
  - BCD_MAX=9;
  - MAG_LIMIT=128;
  - the 8-bit operand width constant used by the display and stack blocks.
- One natural sub-module, dec_mac: combinational mag*10+digit with a 12-bit result and an over-limit flag.
- The FSM and output registers live in decimal_entry.

## Test plan
- rst, then digits 1,2,7, then enter: next cycle value=8'h7F, value_valid=1 for 1 cycle, entry_mag=0, err=0.
- neg, digits 1,2,8, then enter: value=8'h80 (−128), valid pulse; entry_neg returns to 0.
- Digits 1,2,8, then enter with no sign: err=1, no valid pulse, value keeps its prior value; a later clear gives err=0 and IDLE.
- Digits 2,6 then 0 (260), a digit of 12, or a 4th digit 0,0,0,5: each sets err=1 at the offending strobe. In ERROR, enter and digit are ignored.
- digit_stb and enter_stb in the same cycle with entry 4: only enter acts, giving value=4 and a valid pulse; the digit is dropped. clear_stb together with enter_stb: no pulse, entry cleared.
- Mid-entry (entry_mag=45, entry_neg=1) assert rst for 1 cycle: all outputs at reset values; enter then produces no pulse.
